memv_sweep: RTL
===============

# memv_sweep

Sequential sweep engine that drives the per-line valid-bit array of an Icache/Dcache through its ordinary single-port `addr/data_in/write` interface. It either scans all lines and counts the valid ones, or invalidates all lines one per cycle, replacing the flash-clear wire with realisable hardware. It sits beside the cache controller and owns the valid array's port while busy. The controller must not drive the array while `busy` is high.

## Interface
- `LINES`, 256, number of cache lines, and the number of indices swept.
- `AW`, 8, valid-array index width; `2**AW == LINES`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: sweep request; sampled only in IDLE.
- `mode` in 1: 0 = count scan, 1 = invalidate sweep; captured with `start`.
- `busy` out 1: high while a sweep is in progress.
- `done` out 1: one-cycle pulse after the last index is processed.
- `valid_count` out AW+1: number of valid lines found by the last count scan.
- `v_addr` out AW: index to the valid array.
- `v_data_in` out 1: write data to the valid array; always 0.
- `v_write` out 1: write enable to the valid array.
- `v_data_out` in 1: combinational read data from the valid array.

## Operation
- States:
  - IDLE: `start` moves to SCAN.
  - SCAN: after `idx == LINES-1` is processed, moves to DONE.
  - DONE: moves to IDLE unconditionally.
- On accepting `start`:
  - `idx` is set to 0.
  - `mode` is latched into `mode_q`.
  - `valid_count` is cleared to 0.
- SCAN, count mode:
  - `v_addr = idx`, `v_write = 0`.
  - `valid_count <= valid_count + v_data_out` every cycle.
- SCAN, invalidate mode:
  - `v_addr = idx`, `v_write = 1`, `v_data_in = 0`.
  - `valid_count` stays 0.
- `idx` increments by 1 per SCAN cycle, with no wrap; the last index is `LINES-1`.
- Outside SCAN:
  - `v_addr = 0`, `v_write = 0`.
  - `valid_count` holds its value until the next accepted `start`.
- `busy` is high exactly in SCAN. `done` is high exactly in DONE.
- `valid_count` is AW+1 bits so that an all-valid result of 256 is representable.
- Boundary conditions:
  - `start` in SCAN or DONE is ignored and not queued.
  - `mode` changes mid-sweep have no effect.
  - `rst` wins over `start` in the same cycle.
  - `rst` mid-sweep: next cycle IDLE, all outputs at reset values.
  - `rst` mid-sweep in invalidate mode: indices not yet written keep their old values.

## Timing
- Reset values: `busy = 0`, `done = 0`, `valid_count = 0`, `v_addr = 0`, `v_write = 0`, `v_data_in = 0`; state IDLE, `idx = 0`.
- `start` is sampled at edge T:
  - SCAN covers cycles T+1 .. T+LINES.
  - `done` is high in cycle T+LINES+1; IDLE follows in T+LINES+2.
  - The earliest next `start` is accepted at the edge ending T+LINES+2.
- The array read is combinational, so each index costs exactly one cycle in both modes.
- `valid_count` is final when `done` is high.
- An invalidate write to index i takes effect at the edge ending SCAN cycle i.

## Configuration
- `MEMV_SWEEP_COUNT_EN` defined:
  - Count mode is available as described above.
- `MEMV_SWEEP_COUNT_EN` undefined:
  - `mode` is ignored and every sweep is an invalidate sweep.
  - `valid_count` is tied to 0 and the accumulator is not built.
  - Sweep timing is unchanged.

## Structure
- Shared package `memv_sweep_pkg` holds:
  - the state encoding (`S_IDLE`, `S_SCAN`, `S_DONE`);
  - the mode constants (`MODE_COUNT = 0`, `MODE_INV = 1`);
  - the default `LINES` and `AW`.
- One sub-module is natural: `sweep_ctr`, the AW-bit index counter with load-zero, increment, and a terminal flag at `LINES-1`.
- The FSM, the accumulator, and the array-port drive stay in `memv_sweep`.

## Test plan
- Reset:
  - Assert `rst` for 2 cycles with `start` = 1.
  - Expect `busy = 0`, `done = 0`, `valid_count = 0`, `v_write = 0`, `v_addr = 0`, and no sweep starts.
- Count scan, sparse array:
  - Preload lines 3, 17, 255 valid; pulse `start` with `mode = 0` at T.
  - Expect `busy` high during T+1..T+256 and `done` at T+257 with `valid_count = 3`.
  - Expect no write cycles.
- Count scan, full array:
  - All 256 lines valid.
  - Expect `valid_count = 256` (9'h100) at `done`.
- Invalidate sweep:
  - All lines valid; pulse `start` with `mode = 1`.
  - Expect 256 writes to addresses 0..255 in order, `done` at T+257, and every line reading 0 afterwards.
- Start while busy:
  - Pulse `start` again at T+50 and at T+257.
  - Expect both ignored and exactly one `done` pulse.
- Reset mid-sweep:
  - Invalidate sweep; assert `rst` in SCAN at `idx = 100`.
  - Expect IDLE next cycle with `v_write = 0`; lines 0..99 read 0 and lines 100..255 stay valid.

Source files
------------

// File: rtl/memv_sweep_pkg.sv
// Shared types and defaults for the valid-array sweep engine.
package memv_sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic MODE_COUNT = 1'b0;
  localparam logic MODE_INV   = 1'b1;

  localparam int DEF_LINES = 256;
  localparam int DEF_AW    = 8;

endpackage

// File: rtl/memv_sweep_ctr.sv
// Index counter for the sweep: load-zero, increment, terminal flag at LINES-1.
module sweep_ctr #(
  parameter int AW    = 8,
  parameter int LINES = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] idx,
  output logic          last
);

  assign last = (idx == AW'(LINES - 1));

  // Holds at the terminal index rather than wrapping; the next clr reloads it.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= '0;
    end else if (inc && !last) begin
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/memv_sweep.sv
// Sweep engine that owns the cache valid-array port while busy: counts valid lines
// or invalidates every line, one index per cycle. Count mode needs MEMV_SWEEP_COUNT_EN.
module memv_sweep
  import memv_sweep_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int AW    = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   valid_count,
  output logic [AW-1:0] v_addr,
  output logic          v_data_in,
  output logic          v_write,
  input  logic          v_data_out
);

  state_t        state;
  logic          mode_q;
  logic          accept;
  logic          scan;
  logic          last;
  logic [AW-1:0] idx;

  assign accept = (state == S_IDLE) && start;
  assign scan   = (state == S_SCAN);

  sweep_ctr #(
    .AW    (AW),
    .LINES (LINES)
  ) u_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .inc  (scan),
    .idx  (idx),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      mode_q <= MODE_COUNT;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_SCAN;
            busy  <= 1'b1;
`ifdef MEMV_SWEEP_COUNT_EN
            mode_q <= mode;
`else
            mode_q <= MODE_INV;
`endif
          end
        end
        S_SCAN: begin
          if (last) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Write is gated by rst so a reset cycle never commits the index it interrupts.
  assign v_addr    = scan ? idx : '0;
  assign v_write   = scan && (mode_q == MODE_INV) && !rst;
  assign v_data_in = 1'b0;

`ifdef MEMV_SWEEP_COUNT_EN
  logic [AW:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      cnt <= '0;
    end else if (scan && (mode_q == MODE_COUNT)) begin
      cnt <= cnt + {{AW{1'b0}}, v_data_out};
    end
  end

  assign valid_count = cnt;
`else
  logic unused_inputs;

  assign unused_inputs = &{1'b0, mode, v_data_out};
  assign valid_count   = '0;
`endif

endmodule
